sigma_mem_responder: RTL and testbench

Word-addressed main-memory responder serving the Sigma CPU's 17-bit memory port (address bits 15:31, 32-bit words, bit 0 = MSB). Accepts one read or write request at a time through a req/ack handshake, inserts a configurable number of wait states to model core-memory access time, and returns read data with a one-cycle acknowledge. It sits between the CPU state machine and the backing store, and carries big-endian byte-lane write enables for byte and halfword stores.

---
 rtl/sigma_mem_pkg.sv | 29 ++
 rtl/sigma_mem_array.sv | 61 ++++++
 rtl/sigma_mem_responder.sv | 142 ++++++++++++++
 tb/tb_sigma_mem_responder.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sigma_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sigma_mem_pkg
// Description : Shared definitions for the Sigma main-memory responder.
//               Word and lane geometry, the 17-bit big-endian word address
//               range [15:31], the wait-counter width and the responder
//               state encoding.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package sigma_mem_pkg;

    localparam int WORD_W   = 32;   // data word width, bit 0 = MSB
    localparam int LANES    = 4;    // byte lanes per word
    localparam int BYTE_W   = 8;    // bits per lane
    localparam int ADDR_MSB = 15;   // CPU word address occupies bits 15..31
    localparam int ADDR_LSB = 31;
    localparam int CNT_W    = 4;    // wait counter holds 0..15

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_ACK    = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/sigma_mem_array.sv
`default_nettype none
// ============================================================================
// Module      : sigma_mem_array
// Description : Single-port synchronous word RAM with big-endian byte-lane
//               write enables and a registered read port. The read register
//               doubles as the responder's read-data output register: it is
//               cleared by reset, reloaded only by a read, zeroed by rd_clr
//               and otherwise holds its value.
// Ports       : clock   - rising-edge clock
//               reset   - asynchronous active-high reset (read register only)
//               index   - word index
//               wdata   - write data, lane k = wdata[8k:8k+7]
//               lane_we - per-lane write enables, lane 0 = most significant
//               rd_en   - load read register from array
//               rd_clr  - force read register to zero (wins over rd_en)
//               rdata   - registered read data
// Revision    : 1.0 - initial release
// ============================================================================
module sigma_mem_array
    import sigma_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 4096,
    parameter int IDX_W       = 12
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [IDX_W-1:0]  index,
    input  logic [0:WORD_W-1] wdata,
    input  logic [0:LANES-1]  lane_we,
    input  logic              rd_en,
    input  logic              rd_clr,
    output logic [0:WORD_W-1] rdata
);

    logic [0:WORD_W-1] r_mem [DEPTH_WORDS];
    logic [0:WORD_W-1] r_rdata;

    // Storage is deliberately not reset: contents survive a responder reset.
    always_ff @(posedge clock) begin
        for (int k = 0; k < LANES; k++) begin
            if (lane_we[k]) begin
                r_mem[index][BYTE_W*k +: BYTE_W] <= wdata[BYTE_W*k +: BYTE_W];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rdata <= '0;
        end else if (rd_clr) begin
            r_rdata <= '0;
        end else if (rd_en) begin
            r_rdata <= r_mem[index];
        end
    end

    assign rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/sigma_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : sigma_mem_responder
// Description : Word-addressed main-memory responder for the Sigma CPU memory
//               port. Accepts one request at a time, spends WAIT_STATES
//               cycles modelling core access time, performs the access in a
//               single ACCESS cycle and pulses ack (with err for addresses at
//               or beyond DEPTH_WORDS) for one cycle.
// Ports       : clock   - rising-edge clock
//               reset   - asynchronous active-high reset
//               req     - request strobe, sampled only when idle
//               we      - 1 = write, 0 = read
//               addr    - word address [15:31]
//               wdata   - write data [0:31]
//               byte_en - lane enables [0:3], lane k = wdata[8k:8k+7]
//               rdata   - read data, valid with ack, held until next ack
//               ack     - one-cycle completion pulse
//               busy    - high from acceptance through the ack cycle
//               err     - out-of-range flag, coincident with ack
// Revision    : 1.0 - initial release
// ============================================================================
module sigma_mem_responder
    import sigma_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 4096,
    parameter int WAIT_STATES = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   req,
    input  logic                   we,
    input  logic [ADDR_MSB:ADDR_LSB] addr,
    input  logic [0:WORD_W-1]      wdata,
    input  logic [0:LANES-1]       byte_en,
    output logic [0:WORD_W-1]      rdata,
    output logic                   ack,
    output logic                   busy,
    output logic                   err
);

    localparam int              c_IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [CNT_W-1:0] c_WAIT_LOAD = CNT_W'(WAIT_STATES);

    state_t                   r_state;
    logic [CNT_W-1:0]         r_count;
    logic                     r_we;
    logic [ADDR_MSB:ADDR_LSB] r_addr;
    logic [0:WORD_W-1]        r_wdata;
    logic [0:LANES-1]         r_byte_en;
    logic                     r_ack;
    logic                     r_busy;
    logic                     r_err;

    logic                     w_in_range;
    logic                     w_access;
    logic [0:LANES-1]         w_lane_we;
    logic                     w_rd_en;
    logic                     w_rd_clr;

    // Compare the whole 17-bit address so high addresses never alias
    // onto the implemented words.
    assign w_in_range = (32'(r_addr) < 32'(DEPTH_WORDS));
    assign w_access   = (r_state == ST_ACCESS);

    // The array is touched only during ACCESS, so a transaction aborted by
    // reset before that cycle leaves storage untouched.
    assign w_lane_we  = (w_access && r_we && w_in_range) ? r_byte_en : '0;
    assign w_rd_en    = w_access && !r_we && w_in_range;
    assign w_rd_clr   = w_access && !w_in_range;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_count   <= '0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_byte_en <= '0;
            r_ack     <= 1'b0;
            r_busy    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req) begin
                        r_we      <= we;
                        r_addr    <= addr;
                        r_wdata   <= wdata;
                        r_byte_en <= byte_en;
                        r_count   <= c_WAIT_LOAD;
                        r_busy    <= 1'b1;
                        r_state   <= (WAIT_STATES == 0) ? ST_ACCESS : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // Entered with the full load, leaves when it reads 1:
                    // exactly WAIT_STATES cycles spent here.
                    r_count <= r_count - 1'b1;
                    if (r_count == 1) begin
                        r_state <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    r_ack   <= 1'b1;
                    r_err   <= !w_in_range;
                    r_state <= ST_ACK;
                end
                ST_ACK: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    sigma_mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (c_IDX_W)
    ) u_array (
        .clock   (clock),
        .reset   (reset),
        .index   (r_addr[ADDR_LSB-c_IDX_W+1:ADDR_LSB]),
        .wdata   (r_wdata),
        .lane_we (w_lane_we),
        .rd_en   (w_rd_en),
        .rd_clr  (w_rd_clr),
        .rdata   (rdata)
    );

    assign ack  = r_ack;
    assign busy = r_busy;
    assign err  = r_err;

endmodule

`default_nettype wire

// File: tb/tb_sigma_mem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_sigma_mem_responder
// Description : Scoreboard bench. Main instance (DEPTH 4096, 2 wait states)
//               is driven by directed then random requests; a word-level
//               memory model predicts each response, which a monitor pops on
//               every ack. A second instance (DEPTH 64, no wait states)
//               checks cycle-exact latency and the small-depth boundary.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sigma_mem_responder;

    localparam int WS     = 2;
    localparam int DEPTH  = 4096;
    localparam int DEPTH0 = 64;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    always #5 clock = ~clock;

    // main instance
    logic        req = 1'b0, we = 1'b0;
    logic [16:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  byte_en = '0;
    logic [31:0] rdata;
    logic        ack, busy, err;

    // zero-wait instance
    logic        q_req = 1'b0, q_we = 1'b0;
    logic [16:0] q_addr = '0;
    logic [31:0] q_wdata = '0;
    logic [3:0]  q_byte_en = '0;
    logic [31:0] q_rdata;
    logic        q_ack, q_busy, q_err;

    sigma_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
        .clock(clock), .reset(reset), .req(req), .we(we), .addr(addr),
        .wdata(wdata), .byte_en(byte_en), .rdata(rdata), .ack(ack),
        .busy(busy), .err(err)
    );

    sigma_mem_responder #(.DEPTH_WORDS(DEPTH0), .WAIT_STATES(0)) dut0 (
        .clock(clock), .reset(reset), .req(q_req), .we(q_we), .addr(q_addr),
        .wdata(q_wdata), .byte_en(q_byte_en), .rdata(q_rdata), .ack(q_ack),
        .busy(q_busy), .err(q_err)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model_mem [DEPTH];
    logic [31:0] model_rdata = '0;

    // Called once per accepted request, in acceptance order.
    task automatic model_accept(input logic w, input logic [16:0] a, input logic [31:0] d,
                                input logic [3:0] be, input int acc);
        exp_t        e;
        logic [31:0] mask;
        bit          oor;
        oor = (int'(a) >= DEPTH);
        if (oor) begin
            model_rdata = '0;
        end else if (w) begin
            mask = '0;
            for (int k = 0; k < 4; k++)
                if (be[3-k]) mask |= (32'hFF00_0000 >> (8*k));
            model_mem[int'(a)] = (model_mem[int'(a)] & ~mask) | (d & mask);
        end else begin
            model_rdata = model_mem[int'(a)];
        end
        e.rdata = model_rdata;
        e.err   = oor;
        e.acc   = acc;
        sb.push_back(e);
    endtask

    // ---------------- monitor ----------------
    int busy_run = 0;
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (reset) begin
                busy_run = 0;
            end else begin
                if (busy) begin
                    busy_run++;
                end else if (busy_run > 0) begin
                    check("busy_length", 32'(busy_run), 32'(WS + 2));
                    busy_run = 0;
                end
                check("err_only_with_ack", {31'd0, err & ~ack}, 32'd0);
                if (ack) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_ack: got ack=1, expected no ack (t=%0t)", $time);
                    end else begin
                        e = sb.pop_front();
                        check("rdata", rdata, e.rdata);
                        check("err", {31'd0, err}, {31'd0, e.err});
                        check("ack_latency", 32'(cyc - e.acc), 32'(WS + 1));
                        check("busy_at_ack", {31'd0, busy}, 32'd1);
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers (called at a negedge) ----------------
    task automatic issue(input logic w, input logic [16:0] a, input logic [31:0] d,
                         input logic [3:0] be, input int n_acc, input bit spurious);
        req = 1'b1; we = w; addr = a; wdata = d; byte_en = be;
        for (int k = 0; k < n_acc; k++) begin
            // a held request is re-accepted one full access period later
            if (k > 0) repeat (WS + 2) @(posedge clock);
            @(posedge clock);
            @(negedge clock);
            model_accept(w, a, d, be, cyc);
        end
        req = 1'b0;
        we = 1'($urandom); addr = 17'($urandom); wdata = $urandom; byte_en = 4'($urandom);
        if (spurious) begin
            req = 1'b1;
            @(negedge clock);
            req = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((sb.size() != 0 || busy) && t < 100) begin
            @(negedge clock);
            t++;
        end
        n_checks++;
        if (t >= 100) begin
            n_fail++;
            $display("FAIL idle_timeout: got %0d pending responses, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic reset_abort(input logic [16:0] a, input logic [31:0] d);
        req = 1'b1; we = 1'b1; addr = a; wdata = d; byte_en = 4'hF;
        @(posedge clock);
        @(negedge clock);
        req = 1'b0;
        check("abort_busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        check("abort_ack", {31'd0, ack}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_err", {31'd0, err}, 32'd0);
        check("abort_rdata", rdata, 32'd0);
        model_rdata = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (6) @(negedge clock);
    endtask

    task automatic q_txn(input logic w, input logic [16:0] a, input logic [31:0] d,
                         input logic [31:0] exp_rd, input logic exp_err);
        q_req = 1'b1; q_we = w; q_addr = a; q_wdata = d; q_byte_en = 4'hF;
        @(posedge clock);
        @(negedge clock);
        q_req = 1'b0;
        check("ws0_c1_ack", {31'd0, q_ack}, 32'd0);
        check("ws0_c1_busy", {31'd0, q_busy}, 32'd1);
        @(negedge clock);
        check("ws0_c2_ack", {31'd0, q_ack}, 32'd1);
        check("ws0_c2_busy", {31'd0, q_busy}, 32'd1);
        check("ws0_c2_err", {31'd0, q_err}, {31'd0, exp_err});
        check("ws0_c2_rdata", q_rdata, exp_rd);
        @(negedge clock);
        check("ws0_c3_ack", {31'd0, q_ack}, 32'd0);
        check("ws0_c3_busy", {31'd0, q_busy}, 32'd0);
        check("ws0_c3_rdata_held", q_rdata, exp_rd);
    endtask

    // ---------------- main sequence ----------------
    logic [16:0] pool [16];

    initial begin
        repeat (3) @(negedge clock);
        check("reset_rdata", rdata, 32'd0);
        check("reset_ack", {31'd0, ack}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_err", {31'd0, err}, 32'd0);
        check("reset_q_rdata", q_rdata, 32'd0);
        reset = 1'b0;
        @(negedge clock);

        // zero-wait instance: two-cycle latency and depth-64 boundary
        q_txn(1'b1, 17'h0002A, 32'h0F0F_0F0F, 32'h0000_0000, 1'b0);
        q_txn(1'b0, 17'h0002A, 32'h0,         32'h0F0F_0F0F, 1'b0);
        q_txn(1'b1, 17'd63,    32'h1357_9BDF, 32'h0F0F_0F0F, 1'b0);
        q_txn(1'b0, 17'd63,    32'h0,         32'h1357_9BDF, 1'b0);
        q_txn(1'b0, 17'd64,    32'h0,         32'h0000_0000, 1'b1);
        q_txn(1'b0, 17'h0002A, 32'h0,         32'h0F0F_0F0F, 1'b0);

        // directed sequence on the main instance
        issue(1'b1, 17'h00010, 32'h1234_5678, 4'b1111, 1, 1'b0); wait_idle();
        issue(1'b0, 17'h00010, 32'h0,         4'b0000, 1, 1'b0); wait_idle();
        check("plan_read_full", rdata, 32'h1234_5678);
        issue(1'b1, 17'h00010, 32'hAABB_CCDD, 4'b0101, 1, 1'b1); wait_idle();
        issue(1'b0, 17'h00010, 32'h0,         4'b0000, 1, 1'b0); wait_idle();
        check("plan_read_lanes", rdata, 32'h12BB_56DD);
        issue(1'b0, 17'h01000, 32'h0,         4'b0000, 1, 1'b0); wait_idle();
        check("plan_read_oor", rdata, 32'h0000_0000);
        issue(1'b1, 17'h01010, 32'hFFFF_FFFF, 4'b1111, 1, 1'b0); wait_idle();
        issue(1'b1, 17'h00010, 32'hFFFF_FFFF, 4'b0000, 1, 1'b1); wait_idle();
        issue(1'b0, 17'h00010, 32'h0,         4'b0000, 1, 1'b0); wait_idle();
        check("plan_no_alias_no_lanes", rdata, 32'h12BB_56DD);

        issue(1'b1, 17'h00020, 32'hCAFE_F00D, 4'b1111, 1, 1'b0); wait_idle();
        reset_abort(17'h00020, 32'hDEAD_BEEF);
        issue(1'b0, 17'h00020, 32'h0,         4'b0000, 1, 1'b0); wait_idle();
        check("plan_abort_preserved", rdata, 32'hCAFE_F00D);

        // request held through ack: re-accepted the cycle after ack
        issue(1'b0, 17'h00010, 32'h0,         4'b0000, 2, 1'b0); wait_idle();
        issue(1'b1, 17'h00020, 32'h0102_0304, 4'b1100, 3, 1'b0); wait_idle();

        // random phase over a small address pool with boundaries and aliases
        pool[0] = 17'h00000; pool[1] = 17'h00010; pool[2] = 17'h00020;
        pool[3] = 17'd4095;  pool[4] = 17'd4094;
        for (int i = 5; i < 12; i++) pool[i] = 17'($urandom_range(0, DEPTH - 1));
        pool[12] = 17'd4096; pool[13] = 17'h1FFFF; pool[14] = 17'h01010; pool[15] = 17'h10010;
        for (int i = 0; i < 12; i++) begin
            issue(1'b1, pool[i], $urandom, 4'b1111, 1, 1'b0);
            wait_idle();
        end
        for (int i = 0; i < 200; i++) begin
            issue(1'($urandom_range(0, 1)), pool[$urandom_range(0, 15)], $urandom,
                  4'($urandom), ($urandom_range(0, 9) == 0) ? 2 : 1,
                  $urandom_range(0, 3) == 0);
            wait_idle();
        end

        repeat (4) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL global_timeout: got no end of test, expected completion");
        $fatal(1, "global timeout");
    end

endmodule

`default_nettype wire
